// File: rtl/fp_norm_lopd_pipe.sv
// Two-stage normalization front-end for the FP add/sub datapath.
// Stage 1 registers the raw mantissa sum together with its leading-zero count.
// Stage 2 picks zero, carry, subnormal or left-shift handling.
// It then registers the normalized mantissa, the flags and the shift amount
// used by the exponent adjuster.
module fp_norm_lopd_pipe #(
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_MANT = 24,
  parameter int SIZE_LOPD = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sign,
  input  logic [SIZE_EXP-1:0]  i_exp_value,
  input  logic [SIZE_MANT:0]   i_mant_sum,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_sign,
  output logic [SIZE_EXP-1:0]  o_exp_value,
  output logic [SIZE_MANT-1:0] o_mant_norm,
  output logic [SIZE_LOPD-1:0] o_lopd_value,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_zero_flag,
  output logic                 o_sticky
);

  logic                 s1_valid;
  logic                 s1_sign;
  logic [SIZE_EXP-1:0]  s1_exp;
  logic [SIZE_MANT:0]   s1_mant;
  logic [SIZE_LOPD-1:0] s1_lzc;
  logic                 s2_valid;

  logic                 s1_adv;
  logic                 s2_adv;
  logic [SIZE_LOPD-1:0] raw_lzc;
  logic                 lzc_found;

  logic [SIZE_EXP-1:0]  exp_m1;
  logic [SIZE_LOPD-1:0] shift_amt;
  logic [SIZE_MANT-1:0] nxt_mant;
  logic [SIZE_LOPD-1:0] nxt_lopd;
  logic                 nxt_ovf;
  logic                 nxt_unf;
  logic                 nxt_zero;
  logic                 nxt_sticky;

  // A stage may advance when it is empty or when the stage after it is draining.
  assign s2_adv  = ~s2_valid | i_ready;
  assign s1_adv  = ~s1_valid | s2_adv;
  // A flush discards whatever is presented, so input is never refused during one.
  assign o_ready = s1_adv | i_flush;
  assign o_valid = s2_valid;

  // Count leading zeros of the mantissa below the carry bit.
  // The result is the full width when that part of the mantissa is all zeros.
  always_comb begin
    raw_lzc   = '0;
    lzc_found = 1'b0;
    for (int i = SIZE_MANT - 1; i >= 0; i--) begin
      if (!lzc_found) begin
        if (i_mant_sum[i]) begin
          lzc_found = 1'b1;
        end else begin
          raw_lzc = raw_lzc + SIZE_LOPD'(1);
        end
      end
    end
  end

  // Stage 1 captures the operand and its raw leading-zero count on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_lzc   <= '0;
    end else if (i_flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_sign <= i_sign;
        s1_exp  <= i_exp_value;
        s1_mant <= i_mant_sum;
        s1_lzc  <= raw_lzc;
      end
    end
  end

  // Select the normalization case in priority order.
  // The shift is clamped to exp-1 so the adjusted exponent stays at least 1.
  always_comb begin
    exp_m1     = s1_exp - SIZE_EXP'(1);
    if (32'(s1_lzc) <= 32'(exp_m1)) begin
      shift_amt = s1_lzc;
    end else begin
      shift_amt = SIZE_LOPD'(exp_m1);
    end
    nxt_mant   = '0;
    nxt_lopd   = '0;
    nxt_ovf    = 1'b0;
    nxt_unf    = 1'b0;
    nxt_zero   = 1'b0;
    nxt_sticky = 1'b0;
    if (s1_mant == '0) begin
      nxt_zero = 1'b1;
    end else if (s1_mant[SIZE_MANT]) begin
      nxt_ovf    = 1'b1;
      nxt_mant   = s1_mant[SIZE_MANT:1];
      nxt_sticky = s1_mant[0];
    end else if (s1_exp == '0) begin
      nxt_unf  = 1'b1;
      nxt_mant = s1_mant[SIZE_MANT-1:0];
    end else begin
      nxt_mant = s1_mant[SIZE_MANT-1:0] << shift_amt;
      nxt_lopd = shift_amt;
    end
  end

  // Stage 2 registers the results; they hold unchanged while downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid     <= 1'b0;
      o_sign       <= 1'b0;
      o_exp_value  <= '0;
      o_mant_norm  <= '0;
      o_lopd_value <= '0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
      o_zero_flag  <= 1'b0;
      o_sticky     <= 1'b0;
    end else if (i_flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_sign       <= s1_sign;
        o_exp_value  <= s1_exp;
        o_mant_norm  <= nxt_mant;
        o_lopd_value <= nxt_lopd;
        o_overflow   <= nxt_ovf;
        o_underflow  <= nxt_unf;
        o_zero_flag  <= nxt_zero;
        o_sticky     <= nxt_sticky;
      end
    end
  end

endmodule

// File: doc/fp_norm_lopd_pipe.md
Name: fp_norm_lopd_pipe

Overview:
- Two-stage pipelined normalization front-end of the FP add/sub datapath.
- Sits between the mantissa adder and the exponent-adjust stage.
- Takes the raw mantissa sum (with carry-out) and the pre-adjust exponent, and runs a leading-one position detect (LOPD).
- Produces the normalized mantissa plus the overflow/underflow/zero flags and the LOPD shift count that the exponent adjuster consumes. Flow control is valid/ready.

Parameters:
- SIZE_EXP, 8, exponent width.
- SIZE_MANT, 24, mantissa width including the hidden bit.
- SIZE_LOPD, 8, LOPD count width; must satisfy 2^SIZE_LOPD > SIZE_MANT.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous pipeline flush.
- i_valid  in  1  upstream data valid.
- o_ready  out  1  block can accept this cycle.
- i_sign  in  1  result sign.
- i_exp_value  in  SIZE_EXP  pre-adjust exponent.
- i_mant_sum  in  SIZE_MANT+1  adder output; MSB is carry-out.
- o_valid  out  1  output data valid.
- i_ready  in  1  downstream accepts.
- o_sign  out  1  registered sign.
- o_exp_value  out  SIZE_EXP  exponent passed through unchanged.
- o_mant_norm  out  SIZE_MANT  normalized mantissa.
- o_lopd_value  out  SIZE_LOPD  left-shift amount applied.
- o_overflow  out  1  carry-out set; mantissa shifted right 1.
- o_underflow  out  1  no normalization applied (subnormal path).
- o_zero_flag  out  1  mantissa sum is zero.
- o_sticky  out  1  bit lost by right shift.

Behaviour:
- Reset (i_rst_n low, async):
  - Both stage valids clear, so o_valid=0.
  - All data and flag outputs go to 0.
  - o_ready=1 once reset deasserts.
- Stage 1 (S1):
  - Captures sign, exp and mant_sum when i_valid & o_ready.
  - Computes the raw LOPD count = number of leading zeros of mant_sum[SIZE_MANT-1:0].
  - The count is registered in S1.
- Stage 2 (S2) computes from the S1 registers and registers all outputs, in this priority:
  1. mant_sum == 0: zero_flag=1, lopd=0, mant_norm=0; overflow and underflow are 0.
  2. mant_sum[SIZE_MANT]=1: overflow=1, mant_norm = mant_sum[SIZE_MANT:1], sticky = mant_sum[0], lopd=0.
  3. exp == 0: underflow=1, mant_norm = mant_sum[SIZE_MANT-1:0] unshifted, lopd=0.
  4. Otherwise, shift = min(raw count, exp-1):
     - mant_norm = mant_sum[SIZE_MANT-1:0] << shift;
     - lopd = shift.
     - The clamp guarantees that exp - lopd >= 1 downstream.
  - Flags are mutually exclusive. sticky=0 except in case 2.
- Latency and throughput:
  - Latency is exactly 2 cycles from accept to o_valid with no stall.
  - Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid & ready on the same edge.
  - s2_adv = ~s2_valid | i_ready; s1_adv = ~s1_valid | s2_adv; o_ready = s1_adv (combinational).
  - While o_valid & ~i_ready, all outputs hold stable and S1 holds if full.
  - No bubble is inserted when the pipe is full and i_ready=1.
  - An accept and an output on the same cycle are legal.
- Flush:
  - i_flush clears both valids at the next edge.
  - Input presented on the flush cycle is dropped; o_ready stays 1 during flush.
  - Flush has priority over accept.
- Reset mid-operation drops all in-flight entries immediately; there is no partial output.
- o_exp_value is never modified here. Exponent arithmetic belongs to the exponent-adjust stage.

Test Plan:
- Carry case (SIZE_MANT=24): mant_sum=25'h1800001, exp=8'h80 -> after 2 cycles o_valid=1, overflow=1, mant_norm=24'hC00000, sticky=1, lopd=0.
- Normal left shift: mant_sum=25'h0000F00, exp=8'h80 -> lopd=12, mant_norm=24'hF00000, no flags.
- Clamp: mant_sum=25'h0000001, exp=8'h05 -> lopd=4, mant_norm=24'h000010. Zero: mant_sum=0 -> zero_flag=1, all else 0. Exp=0 with mant_sum=25'h0000400 -> underflow=1, mant_norm unshifted.
- Backpressure: stream 4 back-to-back inputs, hold i_ready=0 for 3 cycles after the first output -> o_ready drops after 2 more accepts, outputs stable while stalled, all 4 outputs in order with no loss or duplication.
- Flush: 2 entries in flight, pulse i_flush -> o_valid=0 next cycle; the next accepted entry emerges alone 2 cycles later.
- Async reset asserted mid-stream between clock edges -> o_valid and outputs go to 0 immediately; the first accept after release produces output at latency 2.
